gray_counter: RTL

Parametrised, fully registered up/down counter that holds binary and Gray-coded values together, with synchronous load and a terminal-count wrap pulse. It generalises the team's combinational binary-to-Gray converter into a sequential block. Its main use is as the read/write pointer source for async FIFOs and other clock-domain-crossing paths, where a glitch-free, single-bit-change Gray output is mandatory.

---
 rtl/gray_pkg.sv | 39 +++
 rtl/gray_encode.sv | 21 ++
 rtl/gray_counter.sv | 103 ++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// ============================================================================
// Module      : gray_pkg
// Description : Binary/Gray conversion helpers and terminal-value helpers
//               shared by the Gray counter family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_pkg;

  localparam int c_max_w = 64;

  typedef logic [c_max_w-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down recovers the binary value.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[c_max_w-1] = g[c_max_w-1];
    for (int i = c_max_w - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic gray_word_t term_ones(input int w);
    return {c_max_w{1'b1}} >> (c_max_w - w);
  endfunction

  function automatic gray_word_t term_zero();
    return '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_encode.sv
// ============================================================================
// Module      : gray_encode
// Description : Combinational WIDTH-bit binary to Gray encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_encode
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = WIDTH'(bin2gray(gray_word_t'(bin)));

endmodule

`default_nettype wire

// File: rtl/gray_counter.sv
// ============================================================================
// Module      : gray_counter
// Description : Registered up/down counter with paired binary and Gray
//               outputs, synchronous load and terminal-count wrap pulse.
//               Define GRAY_COUNTER_SATURATE_EN to saturate at the ends.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_counter
  import gray_pkg::*;
#(
  parameter int          WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_max        = WIDTH'(term_ones(WIDTH));
  localparam logic [WIDTH-1:0] c_zero       = WIDTH'(term_zero());
  localparam logic [WIDTH-1:0] c_reset_bin  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] c_reset_gray = WIDTH'(bin2gray(gray_word_t'(RESET_VAL)));

  generate
    if (WIDTH < 2 || WIDTH > c_max_w) begin : g_bad_width
      $error("gray_counter: WIDTH out of range");
    end
  endgenerate

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_wrap_next;

  always_comb begin
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    if (load) begin
      w_bin_next = load_val;
    end else if (en) begin
      if (up) begin
        if (r_bin == c_max) begin
`ifdef GRAY_COUNTER_SATURATE_EN
          w_bin_next = r_bin;
`else
          w_bin_next  = c_zero;
          w_wrap_next = 1'b1;
`endif
        end else begin
          w_bin_next = r_bin + WIDTH'(1);
        end
      end else begin
        if (r_bin == c_zero) begin
`ifdef GRAY_COUNTER_SATURATE_EN
          w_bin_next = r_bin;
`else
          w_bin_next  = c_max;
          w_wrap_next = 1'b1;
`endif
        end else begin
          w_bin_next = r_bin - WIDTH'(1);
        end
      end
    end
  end

  // Gray is encoded from the next binary value so the output comes straight off a flop.
  gray_encode #(
    .WIDTH (WIDTH)
  ) u_gray_encode (
    .bin  (w_bin_next),
    .gray (w_gray_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= c_reset_bin;
      r_gray <= c_reset_gray;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign bin_q  = r_bin;
  assign gray_q = r_gray;
  assign wrap   = r_wrap;

endmodule

`default_nettype wire
